// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: fetches one byte per cycle, assembles big-endian
// 32-bit words and buffers them with their PC in a small FIFO for decode.
module instr_prefetch_queue #(
    parameter int                ADDR_W   = 8,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic [ADDR_W-1:0]          mem_addr,
    input  logic [7:0]                 mem_byte,
    input  logic                       redirect_valid,
    input  logic [ADDR_W-1:0]          redirect_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instr,
    output logic [ADDR_W-1:0]          out_pc,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    typedef enum logic [2:0] {S_BYTE0, S_BYTE1, S_BYTE2, S_BYTE3, S_HOLD} state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q;
    logic [7:0]         lane0_q, lane1_q, lane2_q;
    logic [31:0]        hold_word_q;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [31:0]        fifo_instr_q [DEPTH];
    logic [ADDR_W-1:0]  fifo_pc_q    [DEPTH];

    logic               push_req;
    logic               push;
    logic               pop;
    logic [31:0]        push_word;

    // A held word must survive until the queue frees a slot; memory is not re-read.
    assign push_word = (state_q == S_HOLD) ? hold_word_q
                                           : {lane0_q, lane1_q, lane2_q, mem_byte};
    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready & ~redirect_valid;
    assign push      = push_req & ~redirect_valid
                     & ((count_q < CNT_W'(DEPTH)) | pop);

    // FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_BYTE0;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_BYTE0: state_d = S_BYTE1;
            S_BYTE1: state_d = S_BYTE2;
            S_BYTE2: state_d = S_BYTE3;
            S_BYTE3: state_d = push ? S_BYTE0 : S_HOLD;
            S_HOLD:  state_d = push ? S_BYTE0 : S_HOLD;
            default: state_d = S_BYTE0;
        endcase
        if (redirect_valid) begin
            state_d = S_BYTE0;
        end
    end

    // FSM: outputs
    always_comb begin
        mem_addr = pc_q;
        push_req = 1'b0;
        unique case (state_q)
            S_BYTE0: mem_addr = pc_q;
            S_BYTE1: mem_addr = pc_q + ADDR_W'(1);
            S_BYTE2: mem_addr = pc_q + ADDR_W'(2);
            S_BYTE3: begin
                mem_addr = pc_q + ADDR_W'(3);
                push_req = 1'b1;
            end
            S_HOLD: begin
                mem_addr = pc_q + ADDR_W'(3);
                push_req = 1'b1;
            end
            default: mem_addr = pc_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q        <= RESET_PC & WORD_MASK;
            lane0_q     <= '0;
            lane1_q     <= '0;
            lane2_q     <= '0;
            hold_word_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            if (state_q == S_BYTE0) lane0_q <= mem_byte;
            if (state_q == S_BYTE1) lane1_q <= mem_byte;
            if (state_q == S_BYTE2) lane2_q <= mem_byte;
            if (state_q == S_BYTE3 && !push) hold_word_q <= push_word;

            if (redirect_valid) begin
                pc_q     <= redirect_pc & WORD_MASK;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) begin
                    pc_q     <= pc_q + ADDR_W'(4);
                    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
                unique case ({push, pop})
                    2'b10:   count_q <= count_q + CNT_W'(1);
                    2'b01:   count_q <= count_q - CNT_W'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // Storage carries no reset; outputs are gated by out_valid instead.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr_q[wr_ptr_q] <= push_word;
            fifo_pc_q[wr_ptr_q]    <= pc_q;
        end
    end

    assign out_instr = out_valid ? fifo_instr_q[rd_ptr_q] : '0;
    assign out_pc    = out_valid ? fifo_pc_q[rd_ptr_q]    : '0;
    assign count     = count_q;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Bench for instr_prefetch_queue: byte memory model, scoreboard of expected
// fetch-stream words, and directed checks on latency, backpressure and flushes.
module tb_instr_prefetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_byte;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [7:0]  out_pc;
    logic [2:0]  count;

    logic [7:0]  imem [256];

    typedef struct {
        logic [7:0]  pc;
        logic [31:0] instr;
    } exp_t;
    exp_t sb [$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_pops   = 0;

    instr_prefetch_queue #(
        .ADDR_W   (8),
        .DEPTH    (4),
        .RESET_PC (8'h00)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_addr       (mem_addr),
        .mem_byte       (mem_byte),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .count          (count)
    );

    always #5 clk = ~clk;

    assign mem_byte = imem[mem_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected fetch stream starting at a word-aligned PC, wrapping mod 256.
    task automatic sb_load(input logic [7:0] start, input int n);
        logic [7:0] p;
        exp_t e;
        sb.delete();
        p = start & 8'hFC;
        for (int i = 0; i < n; i++) begin
            e.pc    = p;
            e.instr = {imem[p], imem[8'(p + 8'd1)], imem[8'(p + 8'd2)], imem[8'(p + 8'd3)]};
            sb.push_back(e);
            p = p + 8'd4;
        end
    endtask

    // Score a pop that will happen on the coming edge, then advance one cycle.
    task automatic step();
        exp_t e;
        if (out_valid && out_ready && !redirect_valid) begin
            if (sb.size() == 0) begin
                check("sb_underrun", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                $display("pop pc=0x%02h instr=0x%08h", out_pc, out_instr);
                check("pop_pc", {24'd0, out_pc}, {24'd0, e.pc});
                check("pop_instr", out_instr, e.instr);
                n_pops++;
            end
        end
        @(posedge clk);
        #1;
        check("count_le_depth", {31'd0, (count <= 3'd4)}, 32'd1);
    endtask

    task automatic redirect_to(input logic [7:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        sb_load(target, 64);
        step();
        redirect_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 8'($urandom);
        imem[0] = 8'h20; imem[1] = 8'h08; imem[2] = 8'h00; imem[3] = 8'h05;
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
        out_ready      = 1'b0;

        // Reset state and first-word latency
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_count", {29'd0, count}, 32'd0);
        check("rst_addr", {24'd0, mem_addr}, 32'd0);
        check("rst_instr", out_instr, 32'd0);
        check("rst_pc", {24'd0, out_pc}, 32'd0);
        reset = 1'b1;
        sb_load(8'h00, 64);
        repeat (3) step();
        check("lat_valid_e3", {31'd0, out_valid}, 32'd0);
        step();
        check("lat_valid_e4", {31'd0, out_valid}, 32'd1);
        check("lat_instr", out_instr, 32'h20080005);
        check("lat_pc", {24'd0, out_pc}, 32'd0);
        check("lat_count", {29'd0, count}, 32'd1);

        // Fill, HOLD, and pop+push on the same edge while full
        repeat (12) step();
        check("full_count", {29'd0, count}, 32'd4);
        repeat (4) step();
        check("hold_addr", {24'd0, mem_addr}, 32'h13);
        check("hold_count", {29'd0, count}, 32'd4);
        check("hold_head_stable", out_instr, 32'h20080005);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("popush_count", {29'd0, count}, 32'd4);
        check("popush_addr", {24'd0, mem_addr}, 32'h14);
        out_ready = 1'b1;
        repeat (8) step();

        // Redirect during BYTE2 with two entries queued
        out_ready = 1'b0;
        redirect_to(8'h80);
        repeat (10) step();
        check("pre_redir_count", {29'd0, count}, 32'd2);
        check("pre_redir_addr", {24'd0, mem_addr}, 32'h8A);
        redirect_to(8'h41);
        check("redir_valid", {31'd0, out_valid}, 32'd0);
        check("redir_count", {29'd0, count}, 32'd0);
        check("redir_addr", {24'd0, mem_addr}, 32'h40);
        repeat (3) step();
        check("redir_lat_e3", {31'd0, out_valid}, 32'd0);
        step();
        check("redir_first_valid", {31'd0, out_valid}, 32'd1);
        check("redir_first_pc", {24'd0, out_pc}, 32'h40);
        out_ready = 1'b1;
        repeat (8) step();

        // PC wrap past the top of memory
        redirect_to(8'hFC);
        repeat (4) step();
        check("wrap_valid", {31'd0, out_valid}, 32'd1);
        check("wrap_pc_fc", {24'd0, out_pc}, 32'hFC);
        repeat (4) step();
        check("wrap_pc_00", {24'd0, out_pc}, 32'h00);
        repeat (8) step();

        // Redirect wins over a pop in the same cycle
        out_ready = 1'b0;
        repeat (8) step();
        check("pre_flush_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        redirect_to(8'h20);
        check("flush_count", {29'd0, count}, 32'd0);
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        repeat (3) step();
        check("flush_lat_e3", {31'd0, out_valid}, 32'd0);
        step();
        check("flush_first_pc", {24'd0, out_pc}, 32'h20);
        check("flush_first_count", {29'd0, count}, 32'd1);
        repeat (8) step();

        // Asynchronous reset mid-assembly with a full queue
        out_ready = 1'b0;
        redirect_to(8'h00);
        repeat (16) step();
        check("pre_rst_count", {29'd0, count}, 32'd4);
        repeat (2) step();
        check("pre_rst_addr", {24'd0, mem_addr}, 32'h12);
        reset = 1'b0;
        #1;
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_count", {29'd0, count}, 32'd0);
        check("arst_addr", {24'd0, mem_addr}, 32'd0);
        sb_load(8'h00, 64);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) step();
        check("arst_lat_e3", {31'd0, out_valid}, 32'd0);
        step();
        check("arst_lat_valid", {31'd0, out_valid}, 32'd1);
        check("arst_lat_instr", out_instr, 32'h20080005);
        check("arst_lat_pc", {24'd0, out_pc}, 32'd0);
        check("arst_lat_count", {29'd0, count}, 32'd1);
        out_ready = 1'b1;
        repeat (12) step();

        check("pops_seen", {31'd0, (n_pops >= 10)}, 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
